// File: rtl/wwm_scene_renderer.sv
// Pixel renderer and projectile collision responder. Draws sky, ground, player box and projectile
// from a once-per-frame snapshot, and holds Ack towards wwm_sm while a hit is outstanding.
//   state | meaning
//   IDLE  | no projectile in flight
//   FLY   | projectile animating, checked for ground/edge at each frame start
//   HIT   | hit reported, Ack held until animate drops
module wwm_scene_renderer #(
  parameter int H_ACTIVE_START = 144,
  parameter int V_ACTIVE_START = 35,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int GROUND_Y       = 400,
  parameter int PROJ_R         = 4,
  parameter int P1_X0          = 32
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic [9:0]  projectileCenterX,
  input  logic [9:0]  projectileCenterY,
  input  logic        animate,
  output logic        Ack,
  output logic        frameTick,
  output logic [11:0] rgb
);

  localparam logic [9:0]         H_START = 10'(H_ACTIVE_START);
  localparam logic [9:0]         V_START = 10'(V_ACTIVE_START);
  localparam logic [9:0]         P1_XL   = 10'(P1_X0);
  localparam logic [9:0]         P1_XR   = 10'(P1_X0 + 16);
  localparam logic [9:0]         GND_Y   = 10'(GROUND_Y);
  localparam logic [9:0]         BOX_TOP = 10'(GROUND_Y - 16);
  localparam logic [10:0]        GND_Y11 = 11'(GROUND_Y);
  localparam logic [10:0]        R_U11   = 11'(PROJ_R);
  localparam logic signed [10:0] R_S11   = 11'(PROJ_R);
  localparam logic [9:0]         SCR_W   = 10'(SCREEN_W);
  localparam logic [9:0]         SCR_H   = 10'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, FLY, HIT} state_t;

  state_t      state, state_next;
  logic [9:0]  proj_x_q, proj_y_q;
  logic        anim_q;
  logic        frame_start;
  logic [9:0]  x, y;
  logic signed [10:0] dx, dy;
  logic        in_proj, in_box, in_ground, hit_now;
  logic [11:0] rgb_next;

  assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);
  assign x  = hCount - H_START;
  assign y  = vCount - V_START;
  assign dx = $signed({1'b0, x}) - $signed({1'b0, proj_x_q});
  assign dy = $signed({1'b0, y}) - $signed({1'b0, proj_y_q});

  assign in_proj   = anim_q && (dx <= R_S11) && (dx >= -R_S11) && (dy <= R_S11) && (dy >= -R_S11);
  assign in_box    = (x >= P1_XL) && (x < P1_XR) && (y >= BOX_TOP) && (y < GND_Y);
  assign in_ground = (y >= GND_Y);

  always_comb begin
    rgb_next = 12'h4AF;
    if (!bright)        rgb_next = 12'h000;
    else if (in_proj)   rgb_next = 12'hFF0;
    else if (in_box)    rgb_next = 12'hF00;
    else if (in_ground) rgb_next = 12'h0A0;
  end

  // Collision uses the values being latched on this same frame-start edge.
  assign hit_now = (({1'b0, projectileCenterY} + R_U11) >= GND_Y11) ||
                   (projectileCenterX >= SCR_W) || (projectileCenterY >= SCR_H);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (frame_start && animate) state_next = FLY;
      FLY: begin
        if (frame_start) begin
          if (!animate)     state_next = IDLE;
          else if (hit_now) state_next = HIT;
        end
      end
      HIT:     if (!animate) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      proj_x_q  <= '0;
      proj_y_q  <= '0;
      anim_q    <= 1'b0;
      frameTick <= 1'b0;
      rgb       <= '0;
    end else begin
      state     <= state_next;
      frameTick <= frame_start;
      rgb       <= rgb_next;
      if (frame_start) begin
        proj_x_q <= projectileCenterX;
        proj_y_q <= projectileCenterY;
        anim_q   <= animate;
      end
    end
  end

  assign Ack = (state == HIT);

endmodule

// File: tb/tb_wwm_scene_renderer.sv
// Directed bench for wwm_scene_renderer: table of pixel vectors against a latched frame,
// plus hand sequences for frame latching, the Ack handshake, edge wrap and async reset.
module tb_wwm_scene_renderer;

  logic        clk = 1'b0;
  logic        Reset;
  logic        bright;
  logic [9:0]  hCount, vCount;
  logic [9:0]  projectileCenterX, projectileCenterY;
  logic        animate;
  logic        Ack, frameTick;
  logic [11:0] rgb;

  int checks   = 0;
  int failures = 0;

  wwm_scene_renderer dut (
    .clk(clk), .Reset(Reset), .bright(bright), .hCount(hCount), .vCount(vCount),
    .projectileCenterX(projectileCenterX), .projectileCenterY(projectileCenterY),
    .animate(animate), .Ack(Ack), .frameTick(frameTick), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    int          x;
    int          y;
    logic [11:0] exp_rgb;
  } pix_vec_t;

  pix_vec_t vecs[13];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a screen pixel (bright=1) and return the rendered colour one edge later.
  task automatic pixel(input int px, input int py, output logic [11:0] col);
    bright = 1'b1;
    hCount = 10'(px + 144);
    vCount = 10'(py + 35);
    tick();
    col = rgb;
  endtask

  // Frame-start edge followed by one ordinary cycle; returns Ack/frameTick seen on the start edge.
  task automatic frame(output logic ack_at, output logic ft_at);
    hCount = 10'd0;
    vCount = 10'd0;
    bright = 1'b0;
    tick();
    ack_at = Ack;
    ft_at  = frameTick;
    hCount = 10'd1;
    tick();
  endtask

  logic [11:0] col;
  logic        a, f;

  initial begin
    vecs[0]  = '{1'b1, 100, 450, 12'h0A0};
    vecs[1]  = '{1'b1, 100, 100, 12'h4AF};
    vecs[2]  = '{1'b0, 100, 100, 12'h000};
    vecs[3]  = '{1'b1, 40,  390, 12'hF00};
    vecs[4]  = '{1'b1, 204, 96,  12'hFF0};
    vecs[5]  = '{1'b1, 205, 100, 12'h4AF};
    vecs[6]  = '{1'b1, 196, 104, 12'hFF0};
    vecs[7]  = '{1'b1, 195, 100, 12'h4AF};
    vecs[8]  = '{1'b1, 200, 105, 12'h4AF};
    vecs[9]  = '{1'b1, 32,  384, 12'hF00};
    vecs[10] = '{1'b1, 48,  390, 12'h4AF};
    vecs[11] = '{1'b1, 31,  399, 12'h4AF};
    vecs[12] = '{1'b1, 0,   400, 12'h0A0};

    // Reset with random inputs
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bright = 1'($urandom); hCount = 10'($urandom); vCount = 10'($urandom);
      projectileCenterX = 10'($urandom); projectileCenterY = 10'($urandom);
      animate = 1'($urandom);
      tick();
    end
    chk("reset_rgb", rgb, 12'h000);
    chk("reset_ack", {11'd0, Ack}, 12'd0);
    chk("reset_ft", {11'd0, frameTick}, 12'd0);

    bright = 1'b0; hCount = 10'd5; vCount = 10'd5; animate = 1'b1;
    projectileCenterX = 10'd200; projectileCenterY = 10'd100;
    #2 Reset = 1'b1;
    tick();
    chk("ft_idle", {11'd0, frameTick}, 12'd0);
    frame(a, f);
    chk("ft_pulse", {11'd0, f}, 12'd1);
    chk("ft_one_cycle", {11'd0, frameTick}, 12'd0);

    for (int i = 0; i < 13; i++) begin
      bright = vecs[i].br;
      hCount = 10'(vecs[i].x + 144);
      vCount = 10'(vecs[i].y + 35);
      tick();
      chk($sformatf("vec%0d", i), rgb, vecs[i].exp_rgb);
    end

    // Mid-frame input change must not move the drawn projectile
    projectileCenterX = 10'd300;
    pixel(200, 100, col); chk("midframe_old", col, 12'hFF0);
    pixel(300, 100, col); chk("midframe_new", col, 12'h4AF);
    frame(a, f);
    pixel(300, 100, col); chk("nextframe_new", col, 12'hFF0);
    pixel(200, 100, col); chk("nextframe_old", col, 12'h4AF);

    // Descent to the ground
    projectileCenterY = 10'd300; frame(a, f); chk("fly_300", {11'd0, a}, 12'd0);
    projectileCenterY = 10'd390; frame(a, f); chk("fly_390", {11'd0, a}, 12'd0);
    projectileCenterY = 10'd396; frame(a, f); chk("hit_396", {11'd0, a}, 12'd1);
    projectileCenterY = 10'd100;
    for (int i = 0; i < 3; i++) begin
      frame(a, f);
      chk($sformatf("hold_%0d", i), {11'd0, Ack}, 12'd1);
    end
    animate = 1'b0; hCount = 10'd7; tick();
    chk("ack_drop", {11'd0, Ack}, 12'd0);
    frame(a, f);
    pixel(300, 100, col); chk("anim_off_draw", col, 12'h4AF);

    // Left-edge wrap
    animate = 1'b1; projectileCenterX = 10'd1023; projectileCenterY = 10'd100;
    frame(a, f); chk("wrap_to_fly", {11'd0, a}, 12'd0);
    frame(a, f); chk("wrap_hit", {11'd0, a}, 12'd1);
    animate = 1'b0; tick(); chk("wrap_release", {11'd0, Ack}, 12'd0);

    // Right edge
    animate = 1'b1; projectileCenterX = 10'd640;
    frame(a, f); chk("right_to_fly", {11'd0, a}, 12'd0);
    frame(a, f); chk("right_hit", {11'd0, a}, 12'd1);
    projectileCenterX = 10'd639; frame(a, f); chk("right_hold", {11'd0, a}, 12'd1);

    // Async reset in HIT
    #2 Reset = 1'b0;
    #1;
    chk("async_ack", {11'd0, Ack}, 12'd0);
    chk("async_rgb", rgb, 12'h000);
    tick(); tick();
    animate = 1'b1; projectileCenterX = 10'd200; projectileCenterY = 10'd100;
    hCount = 10'd9; vCount = 10'd9;
    #2 Reset = 1'b1;
    tick();
    chk("post_reset_ack", {11'd0, Ack}, 12'd0);
    pixel(200, 100, col); chk("post_reset_nolatch", col, 12'h4AF);
    frame(a, f); chk("post_reset_fly", {11'd0, a}, 12'd0);
    pixel(200, 100, col); chk("post_reset_draw", col, 12'hFF0);
    frame(a, f); chk("post_reset_noack", {11'd0, a}, 12'd0);

    // Hit and animate drop on the same frame start: back to IDLE, no Ack
    projectileCenterY = 10'd396; animate = 1'b0;
    frame(a, f); chk("simul_noack", {11'd0, a}, 12'd0);
    animate = 1'b1;
    frame(a, f); chk("simul_idle", {11'd0, a}, 12'd0);
    frame(a, f); chk("simul_then_hit", {11'd0, a}, 12'd1);

    // Ground and edge together still just one HIT level
    animate = 1'b0; tick();
    animate = 1'b1; projectileCenterX = 10'd700; projectileCenterY = 10'd500;
    frame(a, f);
    frame(a, f); chk("both_hit", {11'd0, a}, 12'd1);
    animate = 1'b0; tick(); chk("both_release", {11'd0, Ack}, 12'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
